// File: rtl/vote_collector_if.sv
// Handshake and result bundle between a vote source and the vote_collector.
// The collector is the slave; the vote source / result consumer is the master.
interface vote_collector_if;
  logic       start;
  logic       vote_valid;
  logic [1:0] vote_id;
  logic       vote_val;
  logic       vote_ready;
  logic [3:0] ballot;
  logic [2:0] tally;
  logic       done;
  logic       busy;
  logic       dup_err;
  logic       timed_out;

  modport master (
    output start, vote_valid, vote_id, vote_val,
    input  vote_ready, ballot, tally, done, busy, dup_err, timed_out
  );

  modport slave (
    input  start, vote_valid, vote_id, vote_val,
    output vote_ready, ballot, tally, done, busy, dup_err, timed_out
  );
endinterface

// File: rtl/vote_collector.sv
// Poll sequencer for the 4-input voter: collects one vote per voter, flags
// duplicates and timeouts, and reports the ballot with its one-count tally.
module vote_collector #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  vote_collector_if.slave  vc
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_RESULT  = 2'd2;
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  logic [1:0] r_state, w_state_nxt;
  logic [3:0] r_mask, w_mask_nxt;
  logic [3:0] r_ballot, w_ballot_nxt;
  logic [7:0] r_timer, w_timer_nxt;
  logic       r_dup, w_dup_nxt;
  logic       r_to, w_to_nxt;
  logic       w_accept;
  logic [2:0] r_tally;
  logic       r_done, r_busy, r_ready;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_mask_nxt   = r_mask;
    w_ballot_nxt = r_ballot;
    w_timer_nxt  = r_timer;
    w_dup_nxt    = r_dup;
    w_to_nxt     = r_to;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (vc.start) begin
          w_state_nxt  = S_COLLECT;
          w_mask_nxt   = 4'b0000;
          w_ballot_nxt = 4'b0000;
          w_timer_nxt  = 8'd0;
          w_dup_nxt    = 1'b0;
          w_to_nxt     = 1'b0;
        end
      end
      S_COLLECT: begin
        w_timer_nxt = r_timer + 8'd1;
        w_accept    = vc.vote_valid & r_ready;
        if (w_accept) begin
          if (r_mask[vc.vote_id]) begin
            w_dup_nxt = 1'b1;
          end else begin
            w_ballot_nxt[vc.vote_id] = vc.vote_val;
            w_mask_nxt[vc.vote_id]   = 1'b1;
          end
        end
        // A 4th vote landing on the expiry cycle wins over the timeout.
        if (w_mask_nxt == 4'b1111) begin
          w_state_nxt = S_RESULT;
        end else if (r_timer == TIMER_LAST) begin
          w_state_nxt = S_RESULT;
          w_to_nxt    = 1'b1;
        end
      end
      S_RESULT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state decodes so nothing reaches a port
  // combinationally from the inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mask   <= 4'b0000;
      r_ballot <= 4'b0000;
      r_timer  <= 8'd0;
      r_dup    <= 1'b0;
      r_to     <= 1'b0;
      r_tally  <= 3'd0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mask   <= w_mask_nxt;
      r_ballot <= w_ballot_nxt;
      r_timer  <= w_timer_nxt;
      r_dup    <= w_dup_nxt;
      r_to     <= w_to_nxt;
      r_tally  <= popcount4(w_ballot_nxt);
      r_done   <= (w_state_nxt == S_RESULT);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_ready  <= (w_state_nxt == S_COLLECT);
    end
  end

  assign vc.ballot     = r_ballot;
  assign vc.tally      = r_tally;
  assign vc.done       = r_done;
  assign vc.busy       = r_busy;
  assign vc.vote_ready = r_ready;
  assign vc.dup_err    = r_dup;
  assign vc.timed_out  = r_to;

endmodule

// File: tb/tb_vote_collector.sv
// Directed and randomized polls for vote_collector, checked against a
// per-poll reference model built from the poll rules.
module tb_vote_collector;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ntests = 0;
  int   nfail  = 0;

  logic       sv   [TO];
  logic [1:0] sid  [TO];
  logic       sval [TO];
  logic       sst  [TO];

  vote_collector_if vc ();

  vote_collector #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vc    (vc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got running, want finished)");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_sched();
    for (int c = 0; c < TO; c++) begin
      sv[c] = 1'b0; sid[c] = 2'd0; sval[c] = 1'b0; sst[c] = 1'b0;
    end
  endtask

  task automatic add_vote(input int c, input int id, input logic val);
    sv[c] = 1'b1; sid[c] = 2'(id); sval[c] = val;
  endtask

  // Reference: first vote per voter within the poll window counts; the poll
  // closes on the cycle all four have voted, or at the last allowed cycle.
  task automatic model(output logic [3:0] eb, output logic [2:0] et,
                       output logic ed, output logic eto, output int cl);
    bit seen [4];
    int nseen = 0;
    eb = 4'b0000; ed = 1'b0; cl = TO - 1;
    for (int i = 0; i < 4; i++) seen[i] = 1'b0;
    for (int c = 0; c < TO; c++) begin
      if (sv[c]) begin
        if (seen[sid[c]]) ed = 1'b1;
        else begin
          seen[sid[c]] = 1'b1;
          eb[sid[c]] = sval[c];
          nseen++;
        end
      end
      if (nseen == 4) begin
        cl = c;
        break;
      end
    end
    eto = (nseen != 4);
    et  = 3'($countones(eb));
  endtask

  task automatic run_poll(input bit start_in_result);
    logic [3:0] eb;
    logic [2:0] et;
    logic ed, eto;
    int cl;
    model(eb, et, ed, eto, cl);
    vc.start = 1'b1;
    step();
    vc.start = 1'b0;
    chk("open_busy",   vc.busy,       1);
    chk("open_ready",  vc.vote_ready, 1);
    chk("open_ballot", vc.ballot,     0);
    chk("open_dup",    vc.dup_err,    0);
    chk("open_to",     vc.timed_out,  0);
    chk("open_done",   vc.done,       0);
    for (int c = 0; c <= cl; c++) begin
      vc.vote_valid = sv[c];
      vc.vote_id    = sid[c];
      vc.vote_val   = sval[c];
      vc.start      = sst[c];
      step();
      chk("done_timing", vc.done, (c == cl));
    end
    vc.vote_valid = 1'b0;
    vc.start      = start_in_result;
    chk("res_ballot", vc.ballot,     eb);
    chk("res_tally",  vc.tally,      et);
    chk("res_dup",    vc.dup_err,    ed);
    chk("res_to",     vc.timed_out,  eto);
    chk("res_ready",  vc.vote_ready, 0);
    chk("res_busy",   vc.busy,       1);
    step();
    vc.start = 1'b0;
    chk("idle_done",   vc.done,       0);
    chk("idle_busy",   vc.busy,       0);
    chk("idle_ready",  vc.vote_ready, 0);
    chk("idle_ballot", vc.ballot,     eb);
    chk("idle_tally",  vc.tally,      et);
    step();
    chk("hold_busy",   vc.busy,       0);
    chk("hold_ballot", vc.ballot,     eb);
  endtask

  initial begin
    int pos;
    vc.start = 1'b1; vc.vote_valid = 1'b1; vc.vote_id = 2'd1; vc.vote_val = 1'b1;
    rst_n = 1'b0;
    step(); step();
    chk("rst_ballot", vc.ballot,     0);
    chk("rst_tally",  vc.tally,      0);
    chk("rst_done",   vc.done,       0);
    chk("rst_busy",   vc.busy,       0);
    chk("rst_ready",  vc.vote_ready, 0);
    chk("rst_dup",    vc.dup_err,    0);
    chk("rst_to",     vc.timed_out,  0);
    vc.start = 1'b0; vc.vote_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", vc.busy, 0);

    // Full poll
    clr_sched();
    add_vote(0, 0, 1); add_vote(1, 1, 0); add_vote(2, 2, 1); add_vote(3, 3, 1);
    run_poll(1'b0);

    // Timeout with two voters
    clr_sched();
    add_vote(0, 0, 1); add_vote(5, 3, 1);
    run_poll(1'b0);

    // Duplicate vote, also shows timed_out cleared by the new start
    clr_sched();
    add_vote(0, 2, 1); add_vote(1, 2, 0); add_vote(2, 0, 0);
    add_vote(3, 1, 0); add_vote(4, 3, 0);
    run_poll(1'b0);

    // 4th vote on the expiry cycle, starts pulsed in COLLECT and RESULT
    clr_sched();
    add_vote(0, 0, 1); add_vote(1, 1, 1); add_vote(2, 2, 0);
    add_vote(TO - 1, 3, 1);
    sst[5] = 1'b1; sst[9] = 1'b1;
    run_poll(1'b1);

    // Sweep all 16 patterns with random order gaps
    for (int p = 0; p < 16; p++) begin
      logic [3:0] pat;
      pat = 4'(p);
      clr_sched();
      pos = 0;
      for (int i = 0; i < 4; i++) begin
        pos += int'($urandom_range(0, 2));
        add_vote(pos, 3 - i, pat[3 - i]);
        pos++;
      end
      run_poll(1'b0);
    end

    // Fully random polls: duplicates, gaps, stray starts, timeouts
    for (int n = 0; n < 30; n++) begin
      clr_sched();
      for (int c = 0; c < TO; c++) begin
        sv[c]   = ($urandom_range(0, 2) != 0);
        sid[c]  = 2'($urandom_range(0, 3));
        sval[c] = 1'($urandom_range(0, 1));
        sst[c]  = ($urandom_range(0, 7) == 0);
      end
      run_poll(1'($urandom_range(0, 1)));
    end

    // Reset mid-COLLECT abandons the poll
    vc.start = 1'b1;
    step();
    vc.start = 1'b0;
    vc.vote_valid = 1'b1; vc.vote_id = 2'd1; vc.vote_val = 1'b1;
    step();
    step();
    chk("pre_rst_dup", vc.dup_err, 1);
    vc.vote_valid = 1'b1; vc.vote_id = 2'd2;
    rst_n = 1'b0;
    step();
    chk("mid_rst_ballot", vc.ballot,     0);
    chk("mid_rst_tally",  vc.tally,      0);
    chk("mid_rst_done",   vc.done,       0);
    chk("mid_rst_busy",   vc.busy,       0);
    chk("mid_rst_ready",  vc.vote_ready, 0);
    chk("mid_rst_dup",    vc.dup_err,    0);
    chk("mid_rst_to",     vc.timed_out,  0);
    vc.vote_valid = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("after_rst_done", vc.done, 0);
      chk("after_rst_busy", vc.busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
